hwrot_arbiter: RTL and testbench

Arbitrates exclusive access to the hardware root-of-trust core bus (`i_data_in`/`i_add`/`i_control` → `o_data_out`/`o_end_op`) between `N_REQ` requesters, e.g. the host interface and the secure-boot sequencer.

- **Arbitration:** round-robin among the requesters.
- **Ownership:** a granted requester keeps the bus for a whole session.
- **Scrub:** between owners the block forces an address-0 scrub window. Address 0 deselects every crypto core and holds it in reset, which clears state left by the previous owner.
- **Timeout:** a watchdog revokes ownership from a requester that holds the bus too long.

---
 rtl/hwrot_pkg.sv | 23 ++
 rtl/hwrot_arbiter_rr_pick.sv | 37 +++
 rtl/hwrot_arbiter.sv | 152 +++++++++++++++
 tb/tb_hwrot_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hwrot_pkg.sv
// Shared definitions for the root-of-trust bus arbiter: core address map,
// arbiter state encoding and bus width.
package hwrot_pkg;

    localparam int HWROT_BUS_W = 64;

    // Core address map as seen in i_control[63:32]; 0 selects nothing.
    localparam logic [31:0] CORE_NONE   = 32'h00;
    localparam logic [31:0] CORE_SHA2   = 32'h20;
    localparam logic [31:0] CORE_SHA3   = 32'h30;
    localparam logic [31:0] CORE_EDDSA  = 32'h40;
    localparam logic [31:0] CORE_X25519 = 32'h50;
    localparam logic [31:0] CORE_TRNG   = 32'h60;
    localparam logic [31:0] CORE_AES    = 32'h70;
    localparam logic [31:0] CORE_PUF    = 32'h80;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_SCRUB = 2'd2
    } arb_state_e;

endpackage

// File: rtl/hwrot_arbiter_rr_pick.sv
// Rotate-priority encoder: picks the first requester at or after ptr,
// wrapping around, and reports it one-hot and as an index.
import hwrot_pkg::*;

module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((int'(ptr) + gi) % N_REQ);
        end
    endgenerate

    // Scan from the lowest priority upward so the nearest requester wins last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                idx   = cand[i];
                valid = 1'b1;
            end
        end
        grant = valid ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/hwrot_arbiter.sv
// Round-robin owner arbitration of the root-of-trust core bus with an
// address-0 scrub window between owners and an ownership watchdog.
import hwrot_pkg::*;

module hwrot_arbiter #(
    parameter int N_REQ        = 2,
    parameter int TIMEOUT      = 65536,
    parameter int SCRUB_CYCLES = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [N_REQ-1:0]               i_req,
    input  logic [HWROT_BUS_W*N_REQ-1:0]   i_data_in_req,
    input  logic [HWROT_BUS_W*N_REQ-1:0]   i_add_req,
    input  logic [HWROT_BUS_W*N_REQ-1:0]   i_control_req,
    output logic [N_REQ-1:0]               o_grant,
    output logic [N_REQ-1:0]               o_timeout,
    output logic [HWROT_BUS_W-1:0]         o_rdata,
    output logic [1:0]                     o_rend_op,
    output logic [HWROT_BUS_W-1:0]         o_data_in,
    output logic [HWROT_BUS_W-1:0]         o_add,
    output logic [HWROT_BUS_W-1:0]         o_control,
    input  logic [HWROT_BUS_W-1:0]         i_data_out,
    input  logic [1:0]                     i_end_op
);

    localparam int          IDX_W   = (N_REQ > 2) ? 2 : 1;
    localparam int          SC_W    = $clog2(SCRUB_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCRUB_CYCLES - 1);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT) - 32'd1;

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [SC_W-1:0]         scrub_q, scrub_d;
    logic [N_REQ-1:0]        grant_q, grant_d;
    logic [N_REQ-1:0]        timeout_q, timeout_d;
    logic [HWROT_BUS_W-1:0]  rdata_q, rdata_d;
    logic [1:0]              rend_q, rend_d;
    logic [HWROT_BUS_W-1:0]  data_in_q, data_in_d;
    logic [HWROT_BUS_W-1:0]  add_q, add_d;
    logic [HWROT_BUS_W-1:0]  control_q, control_d;

    logic [N_REQ-1:0]        pick_grant;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_valid;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (i_req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        scrub_d   = scrub_q;
        // Everything core-facing defaults to zero: only a live owner opens the path.
        grant_d   = '0;
        timeout_d = '0;
        rdata_d   = '0;
        rend_d    = '0;
        data_in_d = '0;
        add_d     = '0;
        control_d = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_OWN;
                    owner_d = pick_idx;
                    grant_d = pick_grant;
                    ptr_d   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    cnt_d   = '0;
                end
            end
            ARB_OWN: begin
                if (!i_req[owner_q]) begin
                    state_d = ARB_SCRUB;
                    scrub_d = SC_LAST;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    state_d            = ARB_SCRUB;
                    scrub_d            = SC_LAST;
                    timeout_d[owner_q] = 1'b1;
                end else begin
                    grant_d   = grant_q;
                    cnt_d     = cnt_q + 32'd1;
                    data_in_d = i_data_in_req[int'(owner_q)*HWROT_BUS_W +: HWROT_BUS_W];
                    add_d     = i_add_req[int'(owner_q)*HWROT_BUS_W +: HWROT_BUS_W];
                    control_d = i_control_req[int'(owner_q)*HWROT_BUS_W +: HWROT_BUS_W];
                    rdata_d   = i_data_out;
                    rend_d    = i_end_op;
                end
            end
            ARB_SCRUB: begin
                if (scrub_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    scrub_d = scrub_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            scrub_q   <= '0;
            grant_q   <= '0;
            timeout_q <= '0;
            rdata_q   <= '0;
            rend_q    <= '0;
            data_in_q <= '0;
            add_q     <= '0;
            control_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            scrub_q   <= scrub_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
            rdata_q   <= rdata_d;
            rend_q    <= rend_d;
            data_in_q <= data_in_d;
            add_q     <= add_d;
            control_q <= control_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_timeout = timeout_q;
    assign o_rdata   = rdata_q;
    assign o_rend_op = rend_q;
    assign o_data_in = data_in_q;
    assign o_add     = add_q;
    assign o_control = control_q;

endmodule

// File: tb/tb_hwrot_arbiter.sv
// Randomized scoreboard bench for hwrot_arbiter: a cycle-level reference
// model predicts every output cycle, a negedge monitor compares.
module tb_hwrot_arbiter;

    localparam int N    = 2;
    localparam int TO   = 10;
    localparam int SC   = 4;
    localparam int NCYC = 3000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [64*N-1:0]  din_req = '0;
    logic [64*N-1:0]  add_req = '0;
    logic [64*N-1:0]  ctl_req = '0;
    logic [63:0]      dout = '0;
    logic [1:0]       endop = '0;

    logic [N-1:0]     o_grant, o_timeout;
    logic [63:0]      o_rdata, o_data_in, o_add, o_control;
    logic [1:0]       o_rend_op;

    hwrot_arbiter #(
        .N_REQ        (N),
        .TIMEOUT      (TO),
        .SCRUB_CYCLES (SC)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_req         (req),
        .i_data_in_req (din_req),
        .i_add_req     (add_req),
        .i_control_req (ctl_req),
        .o_grant       (o_grant),
        .o_timeout     (o_timeout),
        .o_rdata       (o_rdata),
        .o_rend_op     (o_rend_op),
        .o_data_in     (o_data_in),
        .o_add         (o_add),
        .o_control     (o_control),
        .i_data_out    (dout),
        .i_end_op      (endop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [N-1:0] tmo;
        logic [63:0]  rdata;
        logic [1:0]   rend;
        logic [63:0]  din;
        logic [63:0]  add;
        logic [63:0]  ctl;
    } out_t;

    out_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: mode 0 idle, 1 owned, 2 scrubbing.
    int m_mode = 0, m_ptr = 0, m_owner = 0, m_own = 0, m_scrub = 0;
    int hold[N];
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},   64'(o_grant),   64'd0);
        chk({tag, "_timeout"}, 64'(o_timeout), 64'd0);
        chk({tag, "_rdata"},   o_rdata,        64'd0);
        chk({tag, "_rend"},    64'(o_rend_op), 64'd0);
        chk({tag, "_data_in"}, o_data_in,      64'd0);
        chk({tag, "_add"},     o_add,          64'd0);
        chk({tag, "_control"}, o_control,      64'd0);
    endtask

    // Predict the outputs that follow the edge just taken, from the inputs it sampled.
    task automatic model_step();
        out_t e;
        bit   found;
        e = '0;
        found = 1'b0;
        case (m_mode)
            0: begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_ptr + i) % N;
                    if (!found && req[k]) begin
                        found      = 1'b1;
                        m_owner    = k;
                        m_ptr      = (k + 1) % N;
                        m_mode     = 1;
                        m_own      = 0;
                        e.grant[k] = 1'b1;
                        $display("cycle %0d: grant requester %0d", cyc, k);
                    end
                end
            end
            1: begin
                m_own++;
                if (!req[m_owner]) begin
                    m_mode  = 2;
                    m_scrub = SC;
                    $display("cycle %0d: requester %0d released after %0d cycles", cyc, m_owner, m_own);
                end else if (TO != 0 && m_own == TO) begin
                    m_mode         = 2;
                    m_scrub        = SC;
                    e.tmo[m_owner] = 1'b1;
                    $display("cycle %0d: requester %0d timed out", cyc, m_owner);
                end else begin
                    e.grant[m_owner] = 1'b1;
                    e.din   = din_req[m_owner*64 +: 64];
                    e.add   = add_req[m_owner*64 +: 64];
                    e.ctl   = ctl_req[m_owner*64 +: 64];
                    e.rdata = dout;
                    e.rend  = endop;
                end
            end
            default: begin
                m_scrub--;
                if (m_scrub == 0) m_mode = 0;
            end
        endcase
        exp_q.push_back(e);
    endtask

    task automatic drive_next();
        for (int k = 0; k < N; k++) begin
            if (req[k]) begin
                hold[k]--;
                if (hold[k] <= 0) req[k] = 1'b0;
                // Occasionally drop exactly on the expiry edge.
                if (m_mode == 1 && m_owner == k && m_own == TO - 1 && $urandom_range(0, 2) == 0)
                    req[k] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                req[k]  = 1'b1;
                hold[k] = $urandom_range(1, 16);
            end
        end
        for (int k = 0; k < N; k++) begin
            din_req[k*64 +: 64] = {$urandom, $urandom};
            add_req[k*64 +: 64] = {$urandom, $urandom};
            ctl_req[k*64 +: 64] = {$urandom, $urandom};
        end
        dout  = (m_mode == 1) ? {$urandom, $urandom} : 64'hDEAD_BEEF_0000_0001;
        endop = 2'($urandom);
    endtask

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            out_t e;
            e = exp_q.pop_front();
            chk("grant",    64'(o_grant),   64'(e.grant));
            chk("timeout",  64'(o_timeout), 64'(e.tmo));
            chk("rdata",    o_rdata,        e.rdata);
            chk("rend_op",  64'(o_rend_op), 64'(e.rend));
            chk("data_in",  o_data_in,      e.din);
            chk("add",      o_add,          e.add);
            chk("control",  o_control,      e.ctl);
        end
    end

    initial begin
        bit did_rst;
        did_rst = 1'b0;
        for (int k = 0; k < N; k++) hold[k] = 0;
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        dout = 64'hDEAD_BEEF_0000_0001;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            cyc = c;
            model_step();
            #1 drive_next();
            if (!did_rst && c > NCYC / 2 && m_mode == 1 && m_own >= 1) begin
                did_rst = 1'b1;
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1 chk_all_zero("async_reset");
                chk("reset_queue_empty", 64'(exp_q.size()), 64'd0);
                exp_q.delete();
                @(posedge clk);
                #1 rst_n = 1'b1;
                m_mode = 0;
                m_ptr  = 0;
                $display("cycle %0d: mid-session reset applied", c);
                req     = 2'b11;
                hold[0] = 6;
                hold[1] = 6;
            end
        end

        @(negedge clk);
        #1 chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
